moore_sync_pattern_tx: RTL and testbench

//  Serial frame transmitter, source side of the 1101 sync-detect link.
//  On a start request it emits SYNC_PAT on dout, MSB first, then DATA_W payload bits, MSB first.
//  It then drives GAP_LEN idle zeros and returns to idle.

---
 rtl/moore_sync_pattern_tx.sv | 104 ++++++++++
 tb/tb_moore_sync_pattern_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/moore_sync_pattern_tx.sv
// Serial frame transmitter: sends SYNC_PAT, then the payload (both MSB first), then GAP_LEN idle zeros.
// Outputs decode from registered state only, so dout is glitch-free for the downstream 1101 detector.
module moore_sync_pattern_tx #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1101,
  parameter int                GAP_LEN  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              dout,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_ALL = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [SYNC_W-1:0]   sync_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // One counter is reused for every phase; it is reloaded with the next phase length on each transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = data_in;
          cnt_d   = CNT_W'(SYNC_W - 1);
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        shreg_d = shreg_q << 1;
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(GAP_LEN - 1);
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A shift selects the current sync bit without an index narrower than the counter.
  assign sync_shift = SYNC_PAT >> cnt_q;

  always_comb begin
    dout = 1'b0;
    case (state_q)
      S_SYNC:  dout = sync_shift[0];
      S_DATA:  dout = shreg_q[DATA_W-1];
      default: dout = 1'b0;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_GAP) && (cnt_q == '0);
  assign state = state_q;

endmodule

// File: tb/tb_moore_sync_pattern_tx.sv
// Self-checking bench for moore_sync_pattern_tx: a frame-level model checked every cycle,
// plus directed scenarios with hand-computed literal bit streams.
module tb_moore_sync_pattern_tx;

  localparam int          DATA_W   = 8;
  localparam int          SYNC_W   = 4;
  localparam logic [3:0]  SYNC_PAT = 4'b1101;
  localparam int          GAP_LEN  = 2;
  localparam int          F        = SYNC_W + DATA_W + GAP_LEN;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              dout, busy, done;
  logic [1:0]        state;

  int errors = 0;
  int checks = 0;

  moore_sync_pattern_tx #(
    .DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC_PAT(SYNC_PAT), .GAP_LEN(GAP_LEN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .dout(dout), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // Frame model: position within the frame (-1 = idle) and the whole frame as one bit vector.
  int         mdl_idx = -1;
  logic [F-1:0] mdl_frame = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_idx <= -1;
    end else if (mdl_idx < 0) begin
      if (start) begin
        mdl_idx   <= 0;
        mdl_frame <= {SYNC_PAT, data_in, {GAP_LEN{1'b0}}};
      end
    end else if (mdl_idx == F - 1) begin
      mdl_idx <= -1;
    end else begin
      mdl_idx <= mdl_idx + 1;
    end
  end

  // Behavioural 1101 detector driven by dout, standing in for the downstream receiver.
  logic [2:0] hist = '0;
  logic       det_q = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist  <= '0;
      det_q <= 1'b0;
    end else begin
      hist  <= {hist[1:0], dout};
      det_q <= ({hist, dout} == 4'b1101);
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [DATA_W-1:0] d);
    @(negedge clk);
    start   = s;
    data_in = d;
  endtask

  // Continuous model comparison, away from the active edge.
  always @(negedge clk) begin
    int exp_state;
    logic exp_dout;
    if (mdl_idx < 0)                    exp_state = 0;
    else if (mdl_idx < SYNC_W)          exp_state = 1;
    else if (mdl_idx < SYNC_W + DATA_W) exp_state = 2;
    else                                exp_state = 3;
    exp_dout = (mdl_idx < 0) ? 1'b0 : mdl_frame[F-1-mdl_idx];
    checkOutput("model_dout",  int'(dout),  int'(exp_dout));
    checkOutput("model_busy",  int'(busy),  int'(mdl_idx >= 0));
    checkOutput("model_done",  int'(done),  int'(mdl_idx == F - 1));
    checkOutput("model_state", int'(state), exp_state);
  end

  logic [F-1:0]       cap;
  logic [2*F+1:0]     cap2;
  int                 done_cnt, det_cnt, det_pos, rise_cnt;
  logic               prev_busy;

  initial begin
    // Reset release and idle check
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_idle_state", int'(state), 0);
    checkOutput("reset_idle_busy", int'(busy), 0);

    // Test 1: asynchronous reset mid-cycle takes effect immediately
    applyStimulus(1'b1, 8'h5A);
    applyStimulus(1'b0, 8'h00);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_dout", int'(dout), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_done", int'(done), 0);
    checkOutput("async_rst_state", int'(state), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Tests 2 and 3: frame A5 with an ignored start/3C during the frame
    applyStimulus(1'b1, 8'hA5);
    done_cnt = 0;
    for (int k = 0; k <= F; k++) begin
      @(negedge clk);
      start = (k == 4);
      data_in = (k == 4) ? 8'h3C : 8'h00;
      if (k < F) begin
        cap[F-1-k] = dout;
        checkOutput("frame_a5_busy", int'(busy), 1);
        if (done) done_cnt++;
        if (k == F - 1) checkOutput("frame_a5_done_last", int'(done), 1);
      end else begin
        checkOutput("frame_a5_idle_after", int'(state), 0);
      end
    end
    checkOutput("frame_a5_bits", int'(cap), int'(14'b1101_10100101_00));
    checkOutput("frame_a5_done_count", done_cnt, 1);
    @(negedge clk);
    checkOutput("no_extra_frame", int'(busy), 0);

    // Test 4: reset after E6 of an FF frame, then a clean 00 frame
    applyStimulus(1'b1, 8'hFF);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 reset = 1'b1;
    #1;
    checkOutput("midframe_rst_dout", int'(dout), 0);
    checkOutput("midframe_rst_state", int'(state), 0);
    #1 reset = 1'b0;
    applyStimulus(1'b1, 8'h00);
    for (int k = 0; k < F; k++) begin
      @(negedge clk);
      start = 1'b0;
      cap[F-1-k] = dout;
    end
    checkOutput("frame_00_bits", int'(cap), int'(14'b1101_00000000_00));
    repeat (2) @(negedge clk);

    // Test 5: start held high -> frames every F+1 cycles with one idle cycle between
    applyStimulus(1'b1, 8'h0F);
    rise_cnt  = 0;
    prev_busy = 1'b0;
    for (int k = 0; k < 2 * (F + 1); k++) begin
      @(negedge clk);
      cap2[2*F+1-k] = dout;
      if (busy && !prev_busy) begin
        rise_cnt++;
        checkOutput("b2b_frame_start", k, (rise_cnt == 1) ? 0 : F + 1);
      end
      if (k == F) checkOutput("b2b_idle_gap", int'(busy), 0);
      prev_busy = busy;
      if (k == 2 * F) start = 1'b0;
    end
    checkOutput("b2b_bits", int'(cap2), int'({14'b1101_00001111_00, 1'b0, 14'b1101_00001111_00, 1'b0}));
    checkOutput("b2b_frame_count", rise_cnt, 2);
    repeat (3) @(negedge clk);

    // Test 6: loopback into a 1101 detector, payload 00
    applyStimulus(1'b1, 8'h00);
    det_cnt = 0;
    det_pos = -1;
    for (int k = 0; k <= F + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (det_q) begin
        det_cnt++;
        det_pos = k;
      end
    end
    checkOutput("loopback_det_count", det_cnt, 1);
    checkOutput("loopback_det_pos", det_pos, SYNC_W);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
